// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - default IF/ID field widths and the packed payload carried through the stage
package pipe_pkg;

    localparam int IMM_W   = 16;
    localparam int SHAMT_W = 5;
    localparam int REG_W   = 5;
    localparam int PC_W    = 32;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [IMM_W-1:0]   imm;
        logic [SHAMT_W-1:0] shamt;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
    } if_id_payload_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - generic two-entry (main + skid) valid/ready register with flush
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;
    logic         drain;

    // in_ready depends only on skid state, so no combinational path from out_ready
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign accept    = in_valid && !skid_valid;
    assign drain     = main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                if (accept) begin
                    skid_data <= in_data;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else begin
                if (accept) begin
                    main_data <= in_data;
                end
                main_valid <= accept;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF/ID registered skid stage; IF_ID_STALL_CNT_EN adds a saturating stall counter
module if_id_skid_stage #(
    parameter int IMM_W   = pipe_pkg::IMM_W,
    parameter int SHAMT_W = pipe_pkg::SHAMT_W,
    parameter int REG_W   = pipe_pkg::REG_W,
`ifdef IF_ID_STALL_CNT_EN
    parameter int PC_W    = pipe_pkg::PC_W,
    parameter int CNT_W   = 16
`else
    parameter int PC_W    = pipe_pkg::PC_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IMM_W-1:0]   in_imm,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [REG_W-1:0]   in_rt,
    input  logic [REG_W-1:0]   in_rd,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IMM_W-1:0]   out_imm,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [REG_W-1:0]   out_rt,
    output logic [REG_W-1:0]   out_rd,
`ifdef IF_ID_STALL_CNT_EN
    output logic [PC_W-1:0]    out_pc,
    output logic [CNT_W-1:0]   stall_cnt
`else
    output logic [PC_W-1:0]    out_pc
`endif
);

    import pipe_pkg::*;

    localparam int PAYLOAD_W = $bits(if_id_payload_t);

    if_id_payload_t payload_in;
    if_id_payload_t payload_out;

    always_comb begin
        payload_in       = '0;
        payload_in.pc    = in_pc;
        payload_in.imm   = in_imm;
        payload_in.shamt = in_shamt;
        payload_in.rt    = in_rt;
        payload_in.rd    = in_rd;
    end

    pipe_skid_reg #(
        .W(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (payload_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (payload_out)
    );

    assign out_pc    = payload_out.pc;
    assign out_imm   = payload_out.imm;
    assign out_shamt = payload_out.shamt;
    assign out_rt    = payload_out.rt;
    assign out_rd    = payload_out.rd;

`ifdef IF_ID_STALL_CNT_EN
    // Flush deliberately leaves the count alone; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - randomized and directed checks of if_id_skid_stage against a queue model
module tb_if_id_skid_stage;

    import pipe_pkg::*;

    localparam int TB_CNT_W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  in_imm = '0;
    logic [4:0]   in_shamt = '0;
    logic [4:0]   in_rt = '0;
    logic [4:0]   in_rd = '0;
    logic [31:0]  in_pc = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_imm;
    logic [4:0]   out_shamt;
    logic [4:0]   out_rt;
    logic [4:0]   out_rd;
    logic [31:0]  out_pc;
`ifdef IF_ID_STALL_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    if_id_payload_t q[$];
    bit             zero_exp = 1'b0;
    int             cnt_exp  = 0;

    always #5 clk = ~clk;

`ifdef IF_ID_STALL_CNT_EN
    if_id_skid_stage #(.CNT_W(TB_CNT_W)) dut (
`else
    if_id_skid_stage dut (
`endif
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_imm   (in_imm),
        .in_shamt (in_shamt),
        .in_rt    (in_rt),
        .in_rd    (in_rd),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_imm  (out_imm),
        .out_shamt(out_shamt),
        .out_rt   (out_rt),
        .out_rd   (out_rd),
`ifdef IF_ID_STALL_CNT_EN
        .out_pc   (out_pc),
        .stall_cnt(stall_cnt)
`else
        .out_pc   (out_pc)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic if_id_payload_t mk(input logic [31:0] pc, input logic [15:0] imm,
                                          input logic [4:0] shamt, input logic [4:0] rt,
                                          input logic [4:0] rd);
        if_id_payload_t p;
        p.pc    = pc;
        p.imm   = imm;
        p.shamt = shamt;
        p.rt    = rt;
        p.rd    = rd;
        return p;
    endfunction

    function automatic if_id_payload_t rnd_payload();
        return mk($urandom, 16'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    endfunction

    // One clock: drive inputs, advance the FIFO model, then compare just after the edge
    task automatic cycle(input bit r, input bit f, input bit iv, input bit ordy, input if_id_payload_t p);
        bit acc;
        bit drn;
        rst       = r;
        flush     = f;
        in_valid  = iv;
        out_ready = ordy;
        in_pc     = p.pc;
        in_imm    = p.imm;
        in_shamt  = p.shamt;
        in_rt     = p.rt;
        in_rd     = p.rd;

        acc = iv && (q.size() < 2);
        drn = (q.size() > 0) && ordy;

        if (r) cnt_exp = 0;
        else if (q.size() > 0 && !ordy && cnt_exp < (1 << TB_CNT_W) - 1) cnt_exp++;

        zero_exp = r;
        if (r || f) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(p);
        end

        @(posedge clk);
        #1;
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0)
            check("payload", 64'({out_pc, out_imm, out_shamt, out_rt, out_rd}), 64'(q[0]));
        if (zero_exp)
            check("rst_payload", 64'({out_pc, out_imm, out_shamt, out_rt, out_rd}), 64'd0);
`ifdef IF_ID_STALL_CNT_EN
        check("stall_cnt", 64'(stall_cnt), 64'(cnt_exp));
`endif
    endtask

    initial begin
        if_id_payload_t z;
        z = '0;

        cycle(1, 0, 0, 0, z);
        cycle(1, 0, 0, 0, z);

        // single instruction, one-cycle latency
        cycle(0, 0, 1, 1, mk(32'h40, 16'h1234, 5'd3, 5'd8, 5'd9));
        check("first_pc", 64'(out_pc), 64'h40);
        cycle(0, 0, 0, 1, z);

        // back-to-back stream
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, mk(32'(i * 4), 16'(i), 5'(i), 5'(i), 5'(i)));
        cycle(0, 0, 0, 1, z);

        // stall: 0x10 held, 0x14 in skid, 0x18 retried until accepted
        cycle(0, 0, 1, 0, mk(32'h10, 16'h10, 5'd1, 5'd1, 5'd1));
        cycle(0, 0, 1, 0, mk(32'h14, 16'h14, 5'd2, 5'd2, 5'd2));
        cycle(0, 0, 1, 0, mk(32'h18, 16'h18, 5'd3, 5'd3, 5'd3));
        check("held_pc", 64'(out_pc), 64'h10);
        cycle(0, 0, 1, 0, mk(32'h18, 16'h18, 5'd3, 5'd3, 5'd3));
        cycle(0, 0, 1, 1, mk(32'h18, 16'h18, 5'd3, 5'd3, 5'd3));
        cycle(0, 0, 1, 1, mk(32'h18, 16'h18, 5'd3, 5'd3, 5'd3));
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, z);

        // flush with both entries full and a concurrent input
        cycle(0, 0, 1, 0, rnd_payload());
        cycle(0, 0, 1, 0, rnd_payload());
        cycle(0, 1, 1, 0, mk(32'h20, 16'h20, 5'd4, 5'd4, 5'd4));
        cycle(0, 0, 0, 1, z);

        // reset mid-stall
        cycle(0, 0, 1, 0, rnd_payload());
        cycle(0, 0, 1, 0, rnd_payload());
        cycle(1, 0, 0, 0, z);

        // long stall to exercise the counter, then flush, then reset
        cycle(0, 0, 1, 0, rnd_payload());
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, z);
        cycle(0, 1, 0, 0, z);
        cycle(0, 0, 0, 0, z);
        cycle(1, 0, 0, 0, z);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
                  ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60), rnd_payload());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised IF/ID pipeline stage for the 5-stage MIPS core.
- Replaces a pass-through holder with a registered stage that carries the decoded immediate, shift amount, Rt/Rd addresses and PC.
- Stage has a valid/ready handshake, a 2-entry skid buffer and a flush input, so hazard and branch logic can stall or kill fetched instructions without losing or duplicating them.

Parameters:
IMM_W, 16, immediate field width
SHAMT_W, 5, shift-amount field width
REG_W, 5, register-address width (Rt, Rd)
PC_W, 32, program-counter width
CNT_W, 16, stall-counter width (optional feature only)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  kill all held instructions (branch taken or exception)
in_valid  input  1  IF presents an instruction
in_ready  output  1  stage can accept this cycle
in_imm  input  IMM_W  immediate
in_shamt  input  SHAMT_W  shift amount
in_rt  input  REG_W  Rt address
in_rd  input  REG_W  Rd address
in_pc  input  PC_W  instruction PC
out_valid  output  1  ID-side payload valid
out_ready  input  1  ID consumes this cycle
out_imm  output  IMM_W  held immediate
out_shamt  output  SHAMT_W  held shift amount
out_rt  output  REG_W  held Rt
out_rd  output  REG_W  held Rd
out_pc  output  PC_W  held PC
stall_cnt  output  CNT_W  present only with IF_ID_STALL_CNT_EN

Behaviour:
- Clock is clk. Reset is synchronous and active-high.
- Storage: a main register (drives the out_* ports) and a skid register, each with its own valid bit.
- Definitions: accept = in_valid && in_ready; drain = out_valid && out_ready.
- in_ready = !skid_valid. This is a register-driven output with no combinational path from out_ready.
- out_valid = main_valid.
- Reset: main_valid=0, skid_valid=0, all payload registers=0, stall_cnt=0. in_ready reads 1 in the first cycle after reset.
- Latency: an accepted instruction appears on out_* on the next cycle. Sustained throughput is 1 per cycle when out_ready=1.
- Update priority, highest first:
  1. rst.
  2. flush: main_valid=0 and skid_valid=0. Any instruction accepted in the same cycle is discarded. Payload registers are not cleared.
  3. Main empty or drain:
     - If skid_valid: main <- skid; skid <- input if accept, else skid_valid=0.
     - Else: main <- input and main_valid=accept.
  4. Main full and no drain: if accept, skid <- input and skid_valid=1.
- Case 4 is the only way skid fills. Skid full forces in_ready=0 on the next cycle.
- Ordering is strictly FIFO. No instruction is dropped or duplicated except by flush.
- Stability: while out_valid && !out_ready, all out_* ports hold their values.
- Simultaneous drain, accept and skid_valid: skid moves to main and the new input moves to skid in the same cycle.
- Reset asserted mid-stall discards both entries.
- Payload registers are not required to be zero when out_valid=0. Downstream must qualify every field with out_valid.

Optional Feature:
- Macro: IF_ID_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists.
  - Counter increments by 1 in every cycle with out_valid && !out_ready.
  - Saturates at all-ones.
  - Cleared by rst only; flush does not clear it.
- Undefined: stall_cnt port and counter are absent. All other behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - default width constants (IMM_W, SHAMT_W, REG_W, PC_W);
  - typedef if_id_payload_t, a packed struct {pc, imm, shamt, rt, rd}.
- One generic sub-module, pipe_skid_reg, parametrised on payload width. It contains the main/skid registers, the valid bits and the flush logic.
- if_id_skid_stage packs the fields into if_id_payload_t, instantiates pipe_skid_reg, and adds the optional counter.

Test Plan:
- Reset, then in_valid=1 with imm=0x1234, shamt=3, rt=8, rd=9, pc=0x40, out_ready=1 -> out_valid=1 next cycle with identical fields; in_ready stays 1.
- Stream pc=0x00,0x04,0x08,0x0C back-to-back with out_ready=1 -> outputs emerge in order, one per cycle, 1-cycle lag.
- out_ready=0 and feed pc=0x10, 0x14, 0x18:
  - 0x10 is held on the outputs; 0x14 goes to skid; in_ready=0; 0x18 is not accepted.
  - Raise out_ready -> 0x10, 0x14, 0x18 emerge in order with no loss.
- Fill main and skid, then pulse flush with in_valid=1 (pc=0x20) -> next cycle out_valid=0 and in_ready=1; pc=0x20 never appears.
- Assert rst mid-stall with both entries full -> out_valid=0 and in_ready=1 the next cycle; payload registers are 0.
- With IF_ID_STALL_CNT_EN, CNT_W=4: hold out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt saturates at 15; flush leaves it at 15; rst returns it to 0.
